// File: rtl/piece_ram_writer.sv
// ============================================================================
// Module   : piece_ram_writer
// Brief    : Writes, erases or collision-checks an N-cell piece in board RAM.
//            Cell address = (y_anc+yoff)*BOARD_W + (x_anc+xoff).
// Revision : 1.0 - initial multi-mode engine with start/done handshake
// ============================================================================
`default_nettype none

module piece_ram_writer #(
    parameter int BOARD_W  = 10,
    parameter int BOARD_H  = 24,
    parameter int X_W      = 5,
    parameter int Y_W      = 6,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 6,
    parameter int CELLS    = 4,
    parameter int OFF_W    = 2,
    parameter int READ_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [X_W-1:0]         x_anc,
    input  logic [Y_W-1:0]         y_anc,
    input  logic [CELLS*OFF_W-1:0] x_offsets,
    input  logic [CELLS*OFF_W-1:0] y_offsets,
    input  logic [DATA_W-1:0]      colour,
    input  logic [DATA_W-1:0]      ram_rdata,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic                   ram_wren,
    output logic [DATA_W-1:0]      ram_wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   collision
);

    localparam int IDX_W  = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int WAIT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int CX_W   = X_W + 1;
    localparam int CY_W   = Y_W + 1;

    localparam logic [IDX_W-1:0]  c_last_idx  = IDX_W'(CELLS - 1);
    localparam logic [WAIT_W-1:0] c_wait_last = (READ_LAT > 0) ? WAIT_W'(READ_LAT - 1) : '0;
    localparam logic [CX_W-1:0]   c_board_w   = CX_W'(BOARD_W);
    localparam logic [CY_W-1:0]   c_board_h   = CY_W'(BOARD_H);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WREN  = 3'd2,
        S_WRDIS = 3'd3,
        S_RWAIT = 3'd4,
        S_CHK   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [WAIT_W-1:0]        wait_q, wait_d;
    logic                     check_q, check_d;
    logic [X_W-1:0]           x_anc_q, x_anc_d;
    logic [Y_W-1:0]           y_anc_q, y_anc_d;
    logic [CELLS*OFF_W-1:0]   x_offs_q, x_offs_d;
    logic [CELLS*OFF_W-1:0]   y_offs_q, y_offs_d;
    logic [ADDR_W-1:0]        ram_addr_q, ram_addr_d;
    logic                     ram_wren_q, ram_wren_d;
    logic [DATA_W-1:0]        ram_wdata_q, ram_wdata_d;
    logic                     collision_q, collision_d;

    logic [OFF_W-1:0]         w_xoff;
    logic [OFF_W-1:0]         w_yoff;
    logic [CX_W-1:0]          w_cx;
    logic [CY_W-1:0]          w_cy;
    logic                     w_oob;
    logic                     w_last;
    logic [ADDR_W-1:0]        w_addr;

    // Current cell coordinates, bounds test and linear RAM address.
    always_comb begin
        w_xoff = x_offs_q[int'(idx_q)*OFF_W +: OFF_W];
        w_yoff = y_offs_q[int'(idx_q)*OFF_W +: OFF_W];
        w_cx   = CX_W'(x_anc_q) + CX_W'(w_xoff);
        w_cy   = CY_W'(y_anc_q) + CY_W'(w_yoff);
        w_oob  = (w_cx >= c_board_w) || (w_cy >= c_board_h);
        w_last = (idx_q == c_last_idx);
        w_addr = ADDR_W'(w_cy) * ADDR_W'(BOARD_W) + ADDR_W'(w_cx);
    end

    // Next-state and registered-output logic; the per-cell advance is folded
    // into the final cycle of each cell so it costs no extra cycle.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        check_d     = check_q;
        x_anc_d     = x_anc_q;
        y_anc_d     = y_anc_q;
        x_offs_d    = x_offs_q;
        y_offs_d    = y_offs_q;
        ram_addr_d  = ram_addr_q;
        ram_wren_d  = 1'b0;
        ram_wdata_d = ram_wdata_q;
        collision_d = collision_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    check_d     = mode[1];
                    x_anc_d     = x_anc;
                    y_anc_d     = y_anc;
                    x_offs_d    = x_offsets;
                    y_offs_d    = y_offsets;
                    ram_wdata_d = (mode == 2'b00) ? colour : '0;
                    collision_d = 1'b0;
                    idx_d       = '0;
                    state_d     = S_ADDR;
                end
            end
            S_ADDR: begin
                if (check_q) begin
                    if (w_oob) begin
                        collision_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        ram_addr_d = w_addr;
                        wait_d     = '0;
                        state_d    = (READ_LAT == 0) ? S_CHK : S_RWAIT;
                    end
                end else if (w_oob) begin
                    // Off-board cell in write/erase: skip it without touching RAM.
                    if (w_last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_ADDR;
                    end
                end else begin
                    // Enable rises with the address so wren is high only in WREN.
                    ram_addr_d = w_addr;
                    ram_wren_d = 1'b1;
                    state_d    = S_WREN;
                end
            end
            S_WREN: begin
                state_d = S_WRDIS;
            end
            S_WRDIS: begin
                if (w_last) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_ADDR;
                end
            end
            S_RWAIT: begin
                if (wait_q == c_wait_last) begin
                    state_d = S_CHK;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_CHK: begin
                if (ram_rdata != '0) begin
                    collision_d = 1'b1;
                    state_d     = S_DONE;
                end else if (w_last) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_ADDR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            wait_q      <= '0;
            check_q     <= 1'b0;
            x_anc_q     <= '0;
            y_anc_q     <= '0;
            x_offs_q    <= '0;
            y_offs_q    <= '0;
            ram_addr_q  <= '0;
            ram_wren_q  <= 1'b0;
            ram_wdata_q <= '0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            check_q     <= check_d;
            x_anc_q     <= x_anc_d;
            y_anc_q     <= y_anc_d;
            x_offs_q    <= x_offs_d;
            y_offs_q    <= y_offs_d;
            ram_addr_q  <= ram_addr_d;
            ram_wren_q  <= ram_wren_d;
            ram_wdata_q <= ram_wdata_d;
            collision_q <= collision_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_wren  = ram_wren_q;
    assign ram_wdata = ram_wdata_q;
    assign collision = collision_q;
    assign done      = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_piece_ram_writer.sv
// ============================================================================
// Module   : tb_piece_ram_writer
// Brief    : Scoreboard bench for piece_ram_writer with a synchronous RAM model.
// Revision : 1.0 - initial bench
// ============================================================================
`default_nettype none

module tb_piece_ram_writer;

    typedef struct packed {
        logic [7:0] addr;
        logic [5:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] mode;
    logic [4:0] x_anc;
    logic [5:0] y_anc;
    logic [7:0] x_offsets;
    logic [7:0] y_offsets;
    logic [5:0] colour;
    logic [5:0] ram_rdata;
    logic [7:0] ram_addr;
    logic       ram_wren;
    logic [5:0] ram_wdata;
    logic       busy;
    logic       done;
    logic       collision;

    logic       poke_en;
    logic [7:0] poke_addr;
    logic [5:0] poke_data;
    logic [5:0] mem [256] = '{default: '0};

    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];
    wr_t        mon_e;
    logic [7:0] mon_a;
    logic [7:0] prev_addr;
    logic       chk_mode;

    int n_checks = 0;
    int n_pass   = 0;

    piece_ram_writer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .x_anc     (x_anc),
        .y_anc     (y_anc),
        .x_offsets (x_offsets),
        .y_offsets (y_offsets),
        .colour    (colour),
        .ram_rdata (ram_rdata),
        .ram_addr  (ram_addr),
        .ram_wren  (ram_wren),
        .ram_wdata (ram_wdata),
        .busy      (busy),
        .done      (done),
        .collision (collision)
    );

    always #5 clk = ~clk;

    // Board RAM model: one-cycle synchronous read, bench-side preload port.
    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Scoreboard: pop expected writes on wren, expected reads on address change in check mode.
    always @(negedge clk) begin
        if (ram_wren === 1'b1) begin
            n_checks++;
            if (exp_wr.size() == 0) begin
                $display("FAIL unexpected_wren: got addr %0d data %0h, required no write", ram_addr, ram_wdata);
            end else begin
                mon_e = exp_wr.pop_front();
                if (ram_addr !== mon_e.addr || ram_wdata !== mon_e.data)
                    $display("FAIL write: got addr %0d data %0h, required addr %0d data %0h",
                             ram_addr, ram_wdata, mon_e.addr, mon_e.data);
                else n_pass++;
            end
        end
        if (chk_mode && busy === 1'b1 && ram_addr !== prev_addr) begin
            n_checks++;
            if (exp_rd.size() == 0) begin
                $display("FAIL unexpected_read: got addr %0d, required no read", ram_addr);
            end else begin
                mon_a = exp_rd.pop_front();
                if (ram_addr !== mon_a)
                    $display("FAIL read: got addr %0d, required %0d", ram_addr, mon_a);
                else n_pass++;
            end
        end
        prev_addr = ram_addr;
    end

    task automatic poke(input logic [7:0] a, input logic [5:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Drive a start pulse with the O-piece offsets; accepted at the next posedge.
    task automatic launch(input logic [1:0] m, input logic [4:0] xa, input logic [5:0] ya,
                          input logic [5:0] col);
        @(negedge clk);
        mode = m; x_anc = xa; y_anc = ya; colour = col;
        x_offsets = 8'h44; y_offsets = 8'h50;
        start = 1'b1;
    endtask

    // Count cycles after acceptance until done; optionally re-pulse start at cycle pulse_at.
    task automatic run_to_done(input int pulse_at, output int lat, output bit busy_ok);
        lat = -1; busy_ok = 1'b1;
        for (int m = 0; m < 200; m++) begin
            @(negedge clk);
            start = (m == pulse_at);
            if (m == pulse_at) begin x_anc = 5'd0; y_anc = 6'd0; end
            if (done === 1'b1) begin lat = m; break; end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic push_o(input logic [7:0] base, input logic [5:0] d);
        exp_wr.push_back('{addr: base,       data: d});
        exp_wr.push_back('{addr: base + 8'd1,  data: d});
        exp_wr.push_back('{addr: base + 8'd10, data: d});
        exp_wr.push_back('{addr: base + 8'd11, data: d});
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b required 0", done); else n_pass++;
        n_checks++; if (collision !== 1'b0) $display("FAIL reset_collision: got %b required 0", collision); else n_pass++;
        n_checks++; if (ram_wren !== 1'b0) $display("FAIL reset_wren: got %b required 0", ram_wren); else n_pass++;
        n_checks++; if (ram_addr !== 8'd0) $display("FAIL reset_addr: got %0d required 0", ram_addr); else n_pass++;
        n_checks++; if (ram_wdata !== 6'd0) $display("FAIL reset_wdata: got %0h required 0", ram_wdata); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_write_erase(input logic [1:0] m, input logic [5:0] exp_d, input string nm);
        int lat; bit bok;
        push_o(8'd53, exp_d);
        launch(m, 5'd3, 6'd5, 6'h2A);
        run_to_done(-1, lat, bok);
        n_checks++; if (lat != 12) $display("FAIL %s_latency: got %0d required 12", nm, lat); else n_pass++;
        n_checks++; if (!bok) $display("FAIL %s_busy: got low before done, required high", nm); else n_pass++;
        n_checks++; if (collision !== 1'b0) $display("FAIL %s_collision: got %b required 0", nm, collision); else n_pass++;
        n_checks++; if (exp_wr.size() != 0) $display("FAIL %s_writes_left: got %0d pending required 0", nm, exp_wr.size()); else n_pass++;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL %s_done_width: got %b required 0", nm, done); else n_pass++;
        exp_wr.delete();
    endtask

    task automatic test_check(input logic [5:0] v63, input int exp_lat, input logic exp_c, input string nm);
        int lat; bit bok;
        poke(8'd63, v63);
        exp_rd.push_back(8'd53); exp_rd.push_back(8'd54); exp_rd.push_back(8'd63);
        if (!exp_c) exp_rd.push_back(8'd64);
        chk_mode = 1'b1;
        launch(2'b10, 5'd3, 6'd5, 6'h2A);
        run_to_done(-1, lat, bok);
        n_checks++; if (lat != exp_lat) $display("FAIL %s_latency: got %0d required %0d", nm, lat, exp_lat); else n_pass++;
        n_checks++; if (collision !== exp_c) $display("FAIL %s_collision: got %b required %b", nm, collision, exp_c); else n_pass++;
        n_checks++; if (exp_rd.size() != 0) $display("FAIL %s_reads_left: got %0d pending required 0", nm, exp_rd.size()); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (collision !== exp_c) $display("FAIL %s_collision_hold: got %b required %b", nm, collision, exp_c); else n_pass++;
        chk_mode = 1'b0;
        exp_rd.delete();
    endtask

    task automatic test_oob;
        int lat; bit bok;
        exp_rd.push_back(8'd59);
        chk_mode = 1'b1;
        launch(2'b11, 5'd9, 6'd5, 6'h2A);
        run_to_done(-1, lat, bok);
        n_checks++; if (lat != 4) $display("FAIL oob_check_latency: got %0d required 4", lat); else n_pass++;
        n_checks++; if (collision !== 1'b1) $display("FAIL oob_check_collision: got %b required 1", collision); else n_pass++;
        n_checks++; if (exp_rd.size() != 0) $display("FAIL oob_check_reads_left: got %0d required 0", exp_rd.size()); else n_pass++;
        chk_mode = 1'b0;
        exp_rd.delete();
        exp_wr.push_back('{addr: 8'd59, data: 6'h15});
        exp_wr.push_back('{addr: 8'd69, data: 6'h15});
        launch(2'b00, 5'd9, 6'd5, 6'h15);
        run_to_done(-1, lat, bok);
        n_checks++; if (lat != 8) $display("FAIL oob_write_latency: got %0d required 8", lat); else n_pass++;
        n_checks++; if (collision !== 1'b0) $display("FAIL oob_write_collision: got %b required 0", collision); else n_pass++;
        n_checks++; if (exp_wr.size() != 0) $display("FAIL oob_write_left: got %0d required 0", exp_wr.size()); else n_pass++;
        exp_wr.delete();
    endtask

    task automatic test_reset_mid;
        int lat; bit bok; bit hit;
        hit = 1'b0;
        exp_wr.push_back('{addr: 8'd53, data: 6'h11});
        exp_wr.push_back('{addr: 8'd54, data: 6'h11});
        launch(2'b00, 5'd3, 6'd5, 6'h11);
        for (int m = 0; m < 20 && !hit; m++) begin
            @(negedge clk);
            start = 1'b0;
            if (m == 4) begin
                n_checks++; if (ram_wren !== 1'b1) $display("FAIL rst_mid_wren_before: got %b required 1", ram_wren); else n_pass++;
                reset = 1'b1;
                hit = 1'b1;
            end
        end
        @(negedge clk);
        n_checks++; if (ram_wren !== 1'b0) $display("FAIL rst_mid_wren: got %b required 0", ram_wren); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b required 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_mid_done: got %b required 0", done); else n_pass++;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (exp_wr.size() != 0) $display("FAIL rst_mid_writes_left: got %0d required 0", exp_wr.size()); else n_pass++;
        exp_wr.delete();
        push_o(8'd53, 6'h11);
        launch(2'b00, 5'd3, 6'd5, 6'h11);
        run_to_done(-1, lat, bok);
        n_checks++; if (lat != 12) $display("FAIL rst_fresh_latency: got %0d required 12", lat); else n_pass++;
        n_checks++; if (exp_wr.size() != 0) $display("FAIL rst_fresh_left: got %0d required 0", exp_wr.size()); else n_pass++;
        exp_wr.delete();
    endtask

    task automatic test_back_to_back;
        int lat; bit bok;
        push_o(8'd53, 6'h2A);
        launch(2'b00, 5'd3, 6'd5, 6'h2A);
        run_to_done(3, lat, bok);
        n_checks++; if (lat != 12) $display("FAIL b2b_first_latency: got %0d required 12", lat); else n_pass++;
        n_checks++; if (!bok) $display("FAIL b2b_first_busy: got low before done, required high"); else n_pass++;
        n_checks++; if (exp_wr.size() != 0) $display("FAIL b2b_first_left: got %0d required 0", exp_wr.size()); else n_pass++;
        exp_wr.delete();
        // Raise start in the DONE cycle and hold it through the following IDLE cycle.
        push_o(8'd21, 6'h3F);
        mode = 2'b00; x_anc = 5'd1; y_anc = 6'd2; colour = 6'h3F; start = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL b2b_idle_busy: got %b required 0", busy); else n_pass++;
        run_to_done(-1, lat, bok);
        n_checks++; if (lat != 12) $display("FAIL b2b_second_latency: got %0d required 12", lat); else n_pass++;
        n_checks++; if (exp_wr.size() != 0) $display("FAIL b2b_second_left: got %0d required 0", exp_wr.size()); else n_pass++;
        exp_wr.delete();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 2'b00; x_anc = '0; y_anc = '0;
        x_offsets = '0; y_offsets = '0; colour = '0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        chk_mode = 1'b0; prev_addr = '0;
        test_reset();
        test_write_erase(2'b00, 6'h2A, "write");
        test_write_erase(2'b01, 6'h00, "erase");
        test_check(6'h05, 9, 1'b1, "check_hit");
        test_check(6'h00, 12, 1'b0, "check_clear");
        test_oob();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
